mipi_hs_byte_align: RTL and testbench

Single-lane MIPI D-PHY high-speed byte aligner that sits directly downstream of the LVDS DDR input cell. Each `clk` it consumes the posedge/negedge bit pair captured from one pad. It hunts for the HS sync byte 0xB8 at either bit parity, locks the bit offset and emits aligned payload bytes, one every four enabled cycles, to the lane merger.

---
 rtl/mipi_hs_byte_align.sv | 132 +++++++++++++
 tb/tb_mipi_hs_byte_align.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mipi_hs_byte_align.sv
// Single-lane MIPI D-PHY HS byte aligner: hunts for the sync byte at either bit parity and emits aligned bytes.
// Optional build macro SYNC_ERR_TOL_EN accepts a sync byte with a single bit error and reports it on sot_err.
//
// state  | meaning
// IDLE   | lane not in HS, shift register and counters cleared
// HUNT   | searching both windows for the sync byte, timeout running
// LOCKED | bit offset fixed, one payload byte every four enabled cycles
// WAIT   | hunt gave up, idle until hs_en drops
module mipi_hs_byte_align #(
  parameter logic [7:0] SYNC_BYTE    = 8'hB8,
  parameter int         HUNT_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clk_en,
  input  logic       idp,
  input  logic       idn,
  input  logic       hs_en,
  output logic [7:0] byte_out,
  output logic       byte_vld,
  output logic       sot_det,
  output logic       sot_err,
  output logic       hunt_to,
  output logic       locked
);

  localparam int TO_W = (HUNT_TIMEOUT > 2) ? $clog2(HUNT_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(HUNT_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED, WAIT} state_t;

  state_t          state;
  // Only the bits that can still reach a candidate window are kept.
  logic [15:9]     sr;
  logic [15:7]     sr_n;
  logic [7:0]      w0, w1;
  logic [TO_W-1:0] to_cnt;
  logic [1:0]      phase;
  logic            off;
  logic            hit, hit_off, hit_tol;

  always_comb begin
    sr_n    = {idn, idp, sr[15:9]};
    w0      = sr_n[15:8];
    w1      = sr_n[14:7];
    hit     = 1'b0;
    hit_off = 1'b0;
    hit_tol = 1'b0;
    if (w0 == SYNC_BYTE) begin
      hit = 1'b1;
    end else if (w1 == SYNC_BYTE) begin
      hit     = 1'b1;
      hit_off = 1'b1;
    end
`ifdef SYNC_ERR_TOL_EN
    else if ($countones(w0 ^ SYNC_BYTE) == 1) begin
      hit     = 1'b1;
      hit_tol = 1'b1;
    end else if ($countones(w1 ^ SYNC_BYTE) == 1) begin
      hit     = 1'b1;
      hit_off = 1'b1;
      hit_tol = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      sr       <= '0;
      to_cnt   <= TO_LOAD;
      phase    <= 2'd0;
      off      <= 1'b0;
      byte_out <= 8'h00;
      byte_vld <= 1'b0;
      sot_det  <= 1'b0;
      sot_err  <= 1'b0;
      hunt_to  <= 1'b0;
      locked   <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      sot_det  <= 1'b0;
      sot_err  <= 1'b0;
      hunt_to  <= 1'b0;
      // Leaving HS aborts from any state, discarding a partially built byte.
      if (!hs_en) begin
        state  <= IDLE;
        sr     <= '0;
        to_cnt <= TO_LOAD;
        phase  <= 2'd0;
        locked <= 1'b0;
      end else if (clk_en) begin
        case (state)
          IDLE: begin
            sr     <= sr_n[15:9];
            to_cnt <= TO_LOAD;
            phase  <= 2'd0;
            state  <= HUNT;
          end
          HUNT: begin
            sr <= sr_n[15:9];
            if (hit) begin
              off     <= hit_off;
              phase   <= 2'd0;
              sot_det <= 1'b1;
              sot_err <= hit_tol;
              locked  <= 1'b1;
              state   <= LOCKED;
            end else if (to_cnt == '0) begin
              hunt_to <= 1'b1;
              state   <= WAIT;
            end else begin
              to_cnt <= to_cnt - 1'b1;
            end
          end
          LOCKED: begin
            sr    <= sr_n[15:9];
            phase <= phase + 2'd1;
            if (phase == 2'd3) begin
              byte_out <= off ? w1 : w0;
              byte_vld <= 1'b1;
            end
          end
          default: begin
            state <= WAIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mipi_hs_byte_align.sv
// Directed bench for mipi_hs_byte_align: even/odd alignment, clk_en gaps, timeout, abort, sync tolerance, reset.
module tb_mipi_hs_byte_align;

  logic       clk = 1'b0;
  logic       rstn;
  logic       clk_en, idp, idn, hs_en;
  logic [7:0] byte_out;
  logic       byte_vld, sot_det, sot_err, hunt_to, locked;

  mipi_hs_byte_align #(.SYNC_BYTE(8'hB8), .HUNT_TIMEOUT(64)) dut (
    .clk(clk), .rstn(rstn), .clk_en(clk_en), .idp(idp), .idn(idn), .hs_en(hs_en),
    .byte_out(byte_out), .byte_vld(byte_vld), .sot_det(sot_det), .sot_err(sot_err),
    .hunt_to(hunt_to), .locked(locked)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  bit   bits[$];
  int   sot_cnt, sot_edge, err_cnt, to_cnt, to_edge, vld_n, gap_strobes;
  int   vld_edge[4];
  logic [7:0] vld_byte[4];
  logic abort_locked;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
  endtask

  task automatic push_zero(input int n);
    for (int i = 0; i < n; i++) bits.push_back(1'b0);
  endtask

  task automatic go_idle();
    hs_en = 1'b0; clk_en = 1'b1; idp = 1'b0; idn = 1'b0;
    step();
    step();
    bits.delete();
  endtask

  // Drives the bit queue as (idp,idn) pairs; ec counts enabled data edges, 0 = first pair.
  task automatic run_pairs(input bit gap, input int abort_at);
    int ec;
    sot_cnt = 0; sot_edge = -1; err_cnt = 0; to_cnt = 0; to_edge = -1;
    vld_n = 0; gap_strobes = 0; abort_locked = 1'bx;
    hs_en = 1'b1; clk_en = 1'b1; idp = 1'b0; idn = 1'b0;
    step();
    ec = 0;
    for (int i = 0; i < bits.size() / 2; i++) begin
      if (gap) begin
        clk_en = 1'b0; idp = 1'b1; idn = 1'b1;
        step();
        if (byte_vld || sot_det || hunt_to || sot_err) gap_strobes++;
      end
      clk_en = 1'b1;
      idp = bits[2*i];
      idn = bits[2*i+1];
      if (i == abort_at) hs_en = 1'b0;
      step();
      if (sot_det) begin sot_cnt++; sot_edge = ec; end
      if (sot_err) err_cnt++;
      if (hunt_to) begin to_cnt++; to_edge = ec; end
      if (byte_vld) begin
        if (vld_n < 4) begin vld_byte[vld_n] = byte_out; vld_edge[vld_n] = ec; end
        vld_n++;
      end
      if (i == abort_at) begin abort_locked = locked; break; end
      ec++;
    end
  endtask

  task automatic build_sync_stream(input int prefix, input int pad);
    bits.delete();
    push_zero(prefix);
    push_byte(8'h00);
    push_byte(8'hB8);
    push_byte(8'h5A);
    push_byte(8'hC3);
    push_zero(pad);
  endtask

  initial begin
    rstn = 1'b0; clk_en = 1'b0; idp = 1'b0; idn = 1'b0; hs_en = 1'b0;
    step();
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_strobes", {byte_vld, sot_det, sot_err, hunt_to, locked}, 5'b0);
    rstn = 1'b1;
    go_idle();

    // Even alignment: sync ends on idn at pair 7.
    build_sync_stream(0, 4);
    run_pairs(1'b0, -1);
    chk("even_sot_cnt", sot_cnt, 1);
    chk("even_sot_edge", sot_edge, 7);
    chk("even_sot_err", err_cnt, 0);
    chk("even_vld_n", vld_n, 2);
    chk("even_b1", vld_byte[0], 8'h5A);
    chk("even_e4", vld_edge[0], 11);
    chk("even_b2", vld_byte[1], 8'hC3);
    chk("even_e8", vld_edge[1], 15);
    chk("even_locked", locked, 1'b1);

    // Asynchronous reset while locked.
    rstn = 1'b0;
    #1;
    chk("mid_rst_locked", locked, 1'b0);
    chk("mid_rst_byte", byte_out, 8'h00);
    step();
    rstn = 1'b1;
    go_idle();

    // Odd alignment: extra leading bit, sync ends on idp at pair 8.
    build_sync_stream(1, 3);
    run_pairs(1'b0, -1);
    chk("odd_sot_edge", sot_edge, 8);
    chk("odd_vld_n", vld_n, 2);
    chk("odd_b1", vld_byte[0], 8'h5A);
    chk("odd_e4", vld_edge[0], 12);
    chk("odd_b2", vld_byte[1], 8'hC3);
    chk("odd_e8", vld_edge[1], 16);
    go_idle();

    // Odd alignment with clk_en low every other cycle and junk on the pads.
    build_sync_stream(1, 3);
    run_pairs(1'b1, -1);
    chk("gap_sot_edge", sot_edge, 8);
    chk("gap_vld_n", vld_n, 2);
    chk("gap_b1", vld_byte[0], 8'h5A);
    chk("gap_e4", vld_edge[0], 12);
    chk("gap_b2", vld_byte[1], 8'hC3);
    chk("gap_e8", vld_edge[1], 16);
    chk("gap_strobes", gap_strobes, 0);
    go_idle();

    // Timeout on all-zero data.
    push_zero(140);
    run_pairs(1'b0, -1);
    chk("to_cnt", to_cnt, 1);
    chk("to_edge", to_edge, 63);
    chk("to_vld_n", vld_n, 0);
    chk("to_sot", sot_cnt, 0);
    chk("to_locked", locked, 1'b0);
    go_idle();

    // Abort two enabled cycles into the first payload byte.
    build_sync_stream(0, 4);
    run_pairs(1'b0, 10);
    chk("abort_sot", sot_cnt, 1);
    chk("abort_vld_n", vld_n, 0);
    chk("abort_locked", abort_locked, 1'b0);
    go_idle();
    build_sync_stream(0, 4);
    run_pairs(1'b0, -1);
    chk("relock_sot_edge", sot_edge, 7);
    chk("relock_b1", vld_byte[0], 8'h5A);
    go_idle();

    // Sync with one bit wrong.
    push_zero(8);
    push_byte(8'hB9);
    push_zero(120);
    run_pairs(1'b0, -1);
`ifdef SYNC_ERR_TOL_EN
    chk("tol_sot", sot_cnt, 1);
    chk("tol_err", err_cnt, 1);
    chk("tol_sot_edge", sot_edge, 7);
    chk("tol_to", to_cnt, 0);
`else
    chk("tol_sot", sot_cnt, 0);
    chk("tol_err", err_cnt, 0);
    chk("tol_to", to_cnt, 1);
    chk("tol_to_edge", to_edge, 63);
`endif
    go_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
